// File: rtl/boreal_gate_arbiter_if.sv
// Request/response and gate action bundle for boreal_gate_arbiter.
// The master view is the arbiter; the slave view is the requester/gate side.
interface boreal_gate_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*256-1:0] req_payload;
   logic [NREQ-1:0]     req_enable;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ-1:0]     rsp_valid;
   logic [159:0]        rsp_payload;
   logic                act_valid;
   logic [255:0]        act_payload;
   logic                act_ready;
   logic                resp_valid;
   logic [159:0]        resp_payload;
   logic                busy;
   logic [2:0]          grant_id;
   logic                timeout_sticky;
   logic                timeout_clr;

   modport master (
      input  req_valid, req_payload, req_enable, act_ready, resp_valid, resp_payload, timeout_clr,
      output req_ready, rsp_valid, rsp_payload, act_valid, act_payload, busy, grant_id, timeout_sticky
   );

   modport slave (
      output req_valid, req_payload, req_enable, act_ready, resp_valid, resp_payload, timeout_clr,
      input  req_ready, rsp_valid, rsp_payload, act_valid, act_payload, busy, grant_id, timeout_sticky
   );
endinterface

// File: rtl/boreal_gate_arbiter.sv
// Round-robin arbiter sharing the single Central Gate action port between
// NREQ requesters, with a response watchdog that synthesizes a timeout reply.
module boreal_gate_arbiter #(
   parameter int          NREQ           = 4,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] REASON_TIMEOUT = 32'h0000_00FF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   boreal_gate_arbiter_if.master bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

   state_t            r_state, w_state;
   logic [PW-1:0]     r_ptr, w_ptr, r_grant, w_grant, w_pick, w_cand;
   logic [NREQ-1:0]   r_req_ready, w_req_ready, r_rsp_valid, w_rsp_valid, w_elig;
   logic              w_hit;
   logic [159:0]      r_rsp_payload, w_rsp_payload;
   logic [255:0]      r_act_payload, w_act_payload;
   logic              r_act_valid, w_act_valid, r_busy, w_busy, r_sticky, w_sticky;
   logic              r_rdy1, w_rdy1;   // act_ready seen on the previous DRAIN cycle
   logic [31:0]       r_wdog, w_wdog;

   assign bus.req_ready      = r_req_ready;
   assign bus.rsp_valid      = r_rsp_valid;
   assign bus.rsp_payload    = r_rsp_payload;
   assign bus.act_valid      = r_act_valid;
   assign bus.act_payload    = r_act_payload;
   assign bus.busy           = r_busy;
   assign bus.grant_id       = 3'(r_grant);
   assign bus.timeout_sticky = r_sticky;

   // Round-robin pick: first eligible index at or above the pointer, wrapping.
   always_comb begin
      w_elig = bus.req_valid & bus.req_enable;
      w_hit  = 1'b0;
      w_pick = '0;
      w_cand = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_cand = PW'((int'(r_ptr) + k) % NREQ);
         if (!w_hit && w_elig[w_cand]) begin
            w_hit  = 1'b1;
            w_pick = w_cand;
         end
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      w_state       = r_state;
      w_ptr         = r_ptr;
      w_grant       = r_grant;
      w_act_payload = r_act_payload;
      w_act_valid   = r_act_valid;
      w_rsp_payload = r_rsp_payload;
      w_wdog        = r_wdog;
      w_rdy1        = r_rdy1;
      w_req_ready   = '0;
      w_rsp_valid   = '0;
      // A watchdog expiry later in this block overrides the clear.
      w_sticky      = r_sticky & ~bus.timeout_clr;
      case (r_state)
         S_IDLE: begin
            w_act_valid = 1'b0;
            if (w_hit && bus.act_ready) begin
               w_req_ready   = NREQ'(1) << w_pick;
               w_act_payload = bus.req_payload[int'(w_pick)*256 +: 256];
               w_act_valid   = 1'b1;
               w_grant       = w_pick;
               w_ptr         = (w_pick == PW'(NREQ-1)) ? '0 : w_pick + 1'b1;
               w_state       = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus.act_ready) begin
               w_act_valid = 1'b0;
               w_wdog      = '0;
               w_state     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.resp_valid) begin
               w_rsp_payload = bus.resp_payload;
               w_rsp_valid   = NREQ'(1) << r_grant;
               w_state       = S_IDLE;
            end else if (TIMEOUT_CYCLES != 0 && r_wdog == 32'(TIMEOUT_CYCLES-1)) begin
               w_rsp_payload = {32'd0, REASON_TIMEOUT, 64'd0, 32'd0};
               w_rsp_valid   = NREQ'(1) << r_grant;
               w_sticky      = 1'b1;
               w_rdy1        = 1'b0;
               w_state       = S_DRAIN;
            end else if (TIMEOUT_CYCLES != 0) begin
               w_wdog = r_wdog + 32'd1;
            end
         end
         S_DRAIN: begin
            // Late gate responses are swallowed; two idle cycles also prove the gate is free.
            if (bus.resp_valid) begin
               w_rdy1  = 1'b0;
               w_state = S_IDLE;
            end else if (bus.act_ready) begin
               w_rdy1 = 1'b1;
               if (r_rdy1) begin
                  w_rdy1  = 1'b0;
                  w_state = S_IDLE;
               end
            end else begin
               w_rdy1 = 1'b0;
            end
         end
         default: w_state = S_IDLE;
      endcase
      w_busy = (w_state != S_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_ptr         <= '0;
         r_grant       <= '0;
         r_act_payload <= '0;
         r_act_valid   <= 1'b0;
         r_rsp_payload <= '0;
         r_rsp_valid   <= '0;
         r_req_ready   <= '0;
         r_wdog        <= '0;
         r_rdy1        <= 1'b0;
         r_sticky      <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_ptr         <= w_ptr;
         r_grant       <= w_grant;
         r_act_payload <= w_act_payload;
         r_act_valid   <= w_act_valid;
         r_rsp_payload <= w_rsp_payload;
         r_rsp_valid   <= w_rsp_valid;
         r_req_ready   <= w_req_ready;
         r_wdog        <= w_wdog;
         r_rdy1        <= w_rdy1;
         r_sticky      <= w_sticky;
         r_busy        <= w_busy;
      end
   end
endmodule

// File: tb/tb_boreal_gate_arbiter.sv
// Randomized transaction bench for boreal_gate_arbiter (NREQ=4, 16-cycle watchdog).
// The bench plays the requesters and the gate, and predicts each grant and
// response from the round-robin and watchdog rules.
module tb_boreal_gate_arbiter;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_bad;
   int   ptr;
   logic exp_sticky;
   logic [255:0] pay [4];

   localparam logic [159:0] TO_RSP = {32'd0, 32'h0000_00FF, 64'd0, 32'd0};

   boreal_gate_arbiter_if #(.NREQ(4)) bus ();

   boreal_gate_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(16), .REASON_TIMEOUT(32'h0000_00FF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
      n_chk++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // First eligible index at or above p, wrapping over four requesters.
   function automatic int rr(input int p, input logic [3:0] el);
      for (int k = 0; k < 4; k++)
         if (((el >> ((p + k) % 4)) & 4'd1) != 4'd0) return (p + k) % 4;
      return -1;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_ctl"}, {bus.req_ready, bus.rsp_valid, bus.act_valid, bus.busy, bus.grant_id, bus.timeout_sticky}, '0);
      chk({tag, "_act"}, bus.act_payload, '0);
      chk({tag, "_rsp"}, bus.rsp_payload, '0);
   endtask

   // One request through the gate. lat 0..15: gate answers in that WAIT cycle;
   // lat -1: gate never answers (watchdog); lat -2: reset pulled during WAIT.
   task automatic txn(input logic [3:0] v, input logic [3:0] e, input int d, input int h,
                      input int lat, input bit clr_same);
      int gw;
      logic [3:0] oh;
      logic [159:0] r;
      gw = rr(ptr, v & e);
      oh = 4'b0001 << gw;
      for (int i = 0; i < 4; i++) begin
         pay[i] = {8{$urandom()}};
         bus.req_payload[i*256 +: 256] = pay[i];
      end
      bus.req_valid  = v;
      bus.req_enable = e;
      bus.resp_valid = 1'b0;
      bus.act_ready  = (d == 0);
      for (int c = 0; c < d; c++) begin
         @(negedge clk);
         chk("busy_gate_rdy", bus.req_ready, 4'd0);
         chk("busy_gate_act", bus.act_valid, 1'b0);
         chk("busy_gate_bsy", bus.busy, 1'b0);
         chk("busy_gate_rsp", bus.rsp_valid, 4'd0);
         bus.resp_valid = (c == d - 1) ? 1'b0 : 1'($urandom_range(0, 1));
         bus.act_ready  = (c == d - 1);
      end
      @(negedge clk);
      chk("grant_rdy", bus.req_ready, oh);
      chk("grant_act", bus.act_valid, 1'b1);
      chk("grant_pay", bus.act_payload, pay[gw]);
      chk("grant_id", bus.grant_id, 3'(gw));
      chk("grant_bsy", bus.busy, 1'b1);
      chk("grant_rsp", bus.rsp_valid, 4'd0);
      ptr = (gw + 1) % 4;
      bus.req_valid = bus.req_valid & ~oh;
      if ($urandom_range(0, 1) == 1) bus.req_enable = 4'($urandom());
      bus.act_ready  = (h == 0);
      bus.resp_valid = 1'($urandom_range(0, 1));
      for (int c = 0; c < h; c++) begin
         @(negedge clk);
         chk("issue_rdy", bus.req_ready, 4'd0);
         chk("issue_act", bus.act_valid, 1'b1);
         chk("issue_pay", bus.act_payload, pay[gw]);
         bus.act_ready  = (c == h - 1);
         bus.resp_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk("accept_act", bus.act_valid, 1'b0);
      chk("accept_bsy", bus.busy, 1'b1);
      chk("accept_rsp", bus.rsp_valid, 4'd0);
      bus.act_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.req_valid  = 4'd0;
      if (lat == -2) begin
         repeat (3) @(negedge clk);
         #2 rst_n = 1'b0;
         #1 chk_reset("rst_wait");
         ptr = 0;
         exp_sticky = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
      end else if (lat >= 0) begin
         for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk("wait_rsp", bus.rsp_valid, 4'd0);
            chk("wait_bsy", bus.busy, 1'b1);
         end
         r = {5{$urandom()}};
         bus.resp_payload = r;
         bus.resp_valid   = 1'b1;
         @(negedge clk);
         chk("rsp_oh", bus.rsp_valid, oh);
         chk("rsp_pay", bus.rsp_payload, r);
         chk("rsp_bsy", bus.busy, 1'b0);
         chk("rsp_sticky", bus.timeout_sticky, exp_sticky);
         bus.resp_valid = 1'b0;
      end else begin
         for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk("wd_quiet", bus.rsp_valid, 4'd0);
            chk("wd_bsy", bus.busy, 1'b1);
         end
         bus.timeout_clr = clr_same;
         @(negedge clk);
         chk("wd_oh", bus.rsp_valid, oh);
         chk("wd_pay", bus.rsp_payload, TO_RSP);
         chk("wd_sticky", bus.timeout_sticky, 1'b1);
         chk("wd_bsy", bus.busy, 1'b1);
         exp_sticky = 1'b1;
         bus.timeout_clr = 1'b0;
         bus.act_ready = 1'b1;
         @(negedge clk);
         chk("drain_bsy1", bus.busy, 1'b1);
         chk("drain_rsp1", bus.rsp_valid, 4'd0);
         bus.act_ready = 1'b0;
         @(negedge clk);
         chk("drain_bsy2", bus.busy, 1'b1);
         if ($urandom_range(0, 1) == 1) begin
            bus.resp_payload = {5{$urandom()}};
            bus.resp_valid   = 1'b1;
            @(negedge clk);
            chk("late_rsp", bus.rsp_valid, 4'd0);
            chk("late_bsy", bus.busy, 1'b0);
            bus.resp_valid = 1'b0;
         end else begin
            bus.act_ready = 1'b1;
            @(negedge clk);
            chk("drain_bsy3", bus.busy, 1'b1);
            @(negedge clk);
            chk("drain_exit", bus.busy, 1'b0);
            chk("drain_rsp", bus.rsp_valid, 4'd0);
         end
         bus.act_ready   = 1'b0;
         bus.timeout_clr = 1'b1;
         @(negedge clk);
         chk("sticky_clr", bus.timeout_sticky, 1'b0);
         exp_sticky = 1'b0;
         bus.timeout_clr = 1'b0;
      end
   endtask

   initial begin
      logic [3:0] v, e;
      n_chk = 0;
      n_bad = 0;
      ptr = 0;
      exp_sticky = 1'b0;
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.req_payload = '0;
      bus.req_enable = '0;
      bus.act_ready = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_payload = '0;
      bus.timeout_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;

      repeat (5) txn(4'hF, 4'hF, 0, 0, $urandom_range(0, 8), 1'b0);   // fairness 0,1,2,3,0
      txn(4'b0100, 4'hF, 0, 0, 6, 1'b0);                              // single request
      txn(4'b0010, 4'hF, 10, 0, 3, 1'b0);                             // gate busy 10 cycles
      txn(4'b0011, 4'b1101, 0, 1, 2, 1'b0);                           // masked requester 1
      txn(4'b0010, 4'b0010, 0, 0, 2, 1'b0);                           // unmasked later
      txn(4'b1000, 4'hF, 0, 2, -1, 1'b0);                             // watchdog
      txn(4'b0001, 4'hF, 1, 0, -1, 1'b1);                             // clear loses to set
      txn(4'b0100, 4'hF, 0, 0, 15, 1'b0);                             // response on expiry edge

      for (int t = 0; t < 40; t++) begin
         do begin
            v = 4'($urandom());
            e = 4'($urandom());
         end while ((v & e) == 4'd0);
         txn(v, e, $urandom_range(0, 3), $urandom_range(0, 2),
             ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)));
      end

      txn(4'hF, 4'hF, 0, 0, -2, 1'b0);                                // reset mid-WAIT
      txn(4'b1010, 4'hF, 0, 0, 4, 1'b0);                              // lowest eligible after reset

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
